// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle SLL/SRL/SRA/ROL shifter.
// Moves STEP bit positions per clock under a start/busy/done handshake.
module shift_unit_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out,
    output logic               carry
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_SLL = 2'b00,
        M_SRL = 2'b01,
        M_SRA = 2'b10,
        M_ROL = 2'b11
    } mode_e;

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   LW_C   = (SHAMT_W + 1)'(WIDTH);

    state_e             state_q;
    mode_e              mode_q;
    logic [WIDTH-1:0]   w_q, w_d;
    logic               cw_q, cw_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [SHAMT_W-1:0] k_d;
    logic [SHAMT_W:0]   lsh;
    logic [SHAMT_W-1:0] rsh;
    logic [WIDTH-1:0]   out_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;

    // One step of the working register: shift by min(STEP, remaining).
    // For left moves the last bit out is w[WIDTH-k]; for right moves w[k-1].
    always_comb begin
        k_d   = (rem_q < STEP_C) ? rem_q : STEP_C;
        lsh   = LW_C - {1'b0, k_d};
        rsh   = k_d - 1'b1;
        w_d   = w_q;
        cw_d  = cw_q;
        unique case (mode_q)
            M_SLL: begin
                w_d  = w_q << k_d;
                cw_d = w_q[lsh[SHAMT_W-1:0]];
            end
            M_SRL: begin
                w_d  = w_q >> k_d;
                cw_d = w_q[rsh];
            end
            M_SRA: begin
                w_d  = WIDTH'($signed(w_q) >>> k_d);
                cw_d = w_q[rsh];
            end
            M_ROL: begin
                w_d  = (w_q << k_d) | (w_q >> lsh);
                cw_d = w_q[lsh[SHAMT_W-1:0]];
            end
        endcase
        rem_d = rem_q - k_d;
    end

    // Control FSM with registered busy/done/out/carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_SLL;
            w_q     <= '0;
            cw_q    <= 1'b0;
            rem_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (shamt != '0) begin
                            w_q     <= in;
                            mode_q  <= mode_e'(mode);
                            rem_q   <= shamt;
                            cw_q    <= 1'b0;
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            out_q   <= in;
                            carry_q <= 1'b0;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    w_q   <= w_d;
                    cw_q  <= cw_d;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        out_q   <= w_d;
                        carry_q <= cw_d;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed tests for shift_unit_seq.
// Two instances: STEP = 1 and STEP = 4, WIDTH = 16.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  shamt = 4'd0;
    logic [15:0] din = 16'h0;
    logic        busy1, done1, carry1;
    logic        busy4, done4, carry4;
    logic [15:0] out1, out4;
    logic        sel = 1'b0;
    logic        busy_s, done_s, carry_s;
    logic [15:0] out_s;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(16), .STEP(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode),
        .shamt(shamt), .in(din), .busy(busy1), .done(done1),
        .out(out1), .carry(carry1)
    );

    shift_unit_seq #(.WIDTH(16), .STEP(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode),
        .shamt(shamt), .in(din), .busy(busy4), .done(done4),
        .out(out4), .carry(carry4)
    );

    assign busy_s  = sel ? busy4  : busy1;
    assign done_s  = sel ? done4  : done1;
    assign out_s   = sel ? out4   : out1;
    assign carry_s = sel ? carry4 : carry1;

    // Drive a one-cycle start; returns at the negedge of cycle 1.
    task automatic kick(input bit use4, input logic [1:0] m,
                        input logic [3:0] s, input logic [15:0] d);
        @(negedge clk);
        sel   = use4;
        mode  = m;
        shamt = s;
        din   = d;
        if (use4) start4 = 1'b1;
        else      start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Waits for done (bounded); reports done cycle and busy cycles seen.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = -1;
        bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done_s) begin
                cyc = c;
                break;
            end
            if (busy_s) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy1, done1, out1, carry1} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_u1 got %h want 0",
                     {busy1, done1, out1, carry1});
        end
        n_cmp++;
        if ({busy4, done4, out4, carry4} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_u4 got %h want 0",
                     {busy4, done4, out4, carry4});
        end
    endtask

    task automatic test_sll;
        int cyc, bc;
        kick(1'b0, 2'b00, 4'd1, 16'h0FFF);
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL sll_busy_c1 got %b want 1", busy1);
        end
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 2) begin
            n_err++;
            $display("FAIL sll_done_cycle got %0d want 2", cyc);
        end
        n_cmp++;
        if ({out1, carry1} !== {16'h1FFE, 1'b0}) begin
            n_err++;
            $display("FAIL sll_result got %h/%b want 1ffe/0",
                     out1, carry1);
        end
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL sll_busy_done got %b want 0", busy1);
        end
    endtask

    task automatic test_sra;
        int cyc, bc;
        kick(1'b0, 2'b10, 4'd4, 16'h8001);
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 5 || bc !== 4) begin
            n_err++;
            $display("FAIL sra_timing got cyc %0d busy %0d want 5 4",
                     cyc, bc);
        end
        n_cmp++;
        if ({out1, carry1} !== {16'hF800, 1'b0}) begin
            n_err++;
            $display("FAIL sra_a got %h/%b want f800/0", out1, carry1);
        end
        kick(1'b0, 2'b10, 4'd4, 16'h800F);
        wait_done(cyc, bc);
        n_cmp++;
        if ({out1, carry1} !== {16'hF800, 1'b1} || cyc !== 5) begin
            n_err++;
            $display("FAIL sra_b got %h/%b cyc %0d want f800/1 5",
                     out1, carry1, cyc);
        end
    endtask

    task automatic test_step4;
        int cyc, bc;
        kick(1'b1, 2'b11, 4'd15, 16'h8001);
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 5 || bc !== 4) begin
            n_err++;
            $display("FAIL rol_timing got cyc %0d busy %0d want 5 4",
                     cyc, bc);
        end
        n_cmp++;
        if ({out4, carry4} !== {16'hC000, 1'b0}) begin
            n_err++;
            $display("FAIL rol_result got %h/%b want c000/0",
                     out4, carry4);
        end
        kick(1'b1, 2'b00, 4'd15, 16'h0002);
        wait_done(cyc, bc);
        n_cmp++;
        if ({out4, carry4} !== {16'h0000, 1'b1} || cyc !== 5) begin
            n_err++;
            $display("FAIL sll15_s4 got %h/%b cyc %0d want 0000/1 5",
                     out4, carry4, cyc);
        end
        kick(1'b1, 2'b10, 4'd15, 16'hC000);
        wait_done(cyc, bc);
        n_cmp++;
        if ({out4, carry4} !== {16'hFFFF, 1'b1} || cyc !== 5) begin
            n_err++;
            $display("FAIL sra15_s4 got %h/%b cyc %0d want ffff/1 5",
                     out4, carry4, cyc);
        end
        kick(1'b1, 2'b01, 4'd6, 16'h00C0);
        wait_done(cyc, bc);
        n_cmp++;
        if ({out4, carry4} !== {16'h0003, 1'b0} || cyc !== 3) begin
            n_err++;
            $display("FAIL srl6_s4 got %h/%b cyc %0d want 0003/0 3",
                     out4, carry4, cyc);
        end
    endtask

    task automatic test_zero;
        int cyc, bc;
        kick(1'b0, 2'b01, 4'd0, 16'h1234);
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 1 || bc !== 0 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL zero_timing got cyc %0d busy %0d want 1 0",
                     cyc, bc);
        end
        n_cmp++;
        if ({out1, carry1} !== {16'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL zero_result got %h/%b want 1234/0",
                     out1, carry1);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        kick(1'b0, 2'b00, 4'd3, 16'h0001);
        n_cmp++;
        if (out1 !== 16'h1234) begin
            n_err++;
            $display("FAIL b2b_out_hold got %h want 1234", out1);
        end
        @(negedge clk);
        start1 = 1'b1;
        mode   = 2'b01;
        shamt  = 4'd5;
        din    = 16'hFFFF;
        @(negedge clk);
        start1 = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_c3 got busy %b done %b want 1 0",
                     busy1, done1);
        end
        @(negedge clk);
        n_cmp++;
        if (done1 !== 1'b1 || out1 !== 16'h0008) begin
            n_err++;
            $display("FAIL b2b_first got done %b out %h want 1 0008",
                     done1, out1);
        end
        start1 = 1'b1;
        mode   = 2'b01;
        shamt  = 4'd8;
        din    = 16'h0100;
        @(negedge clk);
        start1 = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b1 || out1 !== 16'h0008) begin
            n_err++;
            $display("FAIL b2b_second_busy got %b out %h want 1 0008",
                     busy1, out1);
        end
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc + 4 !== 13 || {out1, carry1} !== {16'h0001, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_second got cyc %0d out %h/%b want 13 0001/0",
                     cyc + 4, out1, carry1);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bc;
        int seen;
        kick(1'b0, 2'b00, 4'd10, 16'hFFFF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy1, done1, out1, carry1} !== 19'h0) begin
            n_err++;
            $display("FAIL rst_mid got %h want 0",
                     {busy1, done1, out1, carry1});
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done1 || busy1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rst_no_done got %0d active want 0", seen);
        end
        kick(1'b0, 2'b00, 4'd2, 16'h0003);
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 3 || {out1, carry1} !== {16'h000C, 1'b0}) begin
            n_err++;
            $display("FAIL rst_after got cyc %0d %h/%b want 3 000c/0",
                     cyc, out1, carry1);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra();
        test_step4();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised multi-cycle shifter for the datapath: the general successor to the fixed one-bit left-shift used for branch/jump offsets. It supports four shift modes and a runtime shift amount. It advances STEP bit positions per clock under a start/busy/done handshake. It also reports the last bit shifted out. The ALU/control unit uses it for shift instructions and for scaled offset generation.

## Interface
- WIDTH, 16, data width; must be a power of two, ≥ 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; shift amounts span 0..WIDTH-1.
- STEP, 1, bit positions shifted per cycle; legal range is 1..WIDTH/2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  2  00 SLL (zero fill), 01 SRL (zero fill), 10 SRA (sign fill), 11 ROL (rotate left).
- shamt  input  SHAMT_W  shift amount; captured with start.
- in  input  WIDTH  operand; captured with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; out/carry valid.
- out  output  WIDTH  result register.
- carry  output  1  last bit shifted/rotated out; 0 when shamt = 0.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE behaviour:
  - With start = 1 and shamt ≠ 0: capture in, mode and shamt into the working registers, set remaining = shamt, go to SHIFT.
  - With start = 1 and shamt = 0: load out = in and carry = 0, go to DONE.
- SHIFT, each cycle:
  - Shift the working register by k = min(STEP, remaining).
  - Fill per mode: SLL and SRL fill with zeros; SRA fills with the captured sign bit; ROL feeds shifted-out bits back into the low end.
  - carry_w takes the last bit leaving the register. For ROL this is the bit that wraps around.
  - remaining -= k.
  - When remaining reaches 0: load out and carry from the post-shift working value, go to DONE.
- DONE: done = 1 for exactly one cycle.
  - start = 1 here is accepted exactly as in IDLE, allowing back-to-back operations.
  - Otherwise go to IDLE.
- start is ignored while in SHIFT; captured operands are never disturbed mid-operation.
- out and carry change only when an operation completes. They hold their value through IDLE and through any following SHIFT until the next completion.
- Arithmetic is exact modulo WIDTH for ROL. For SLL, SRL and SRA the result is identical to a single combinational shift by shamt, regardless of STEP.
- Reset, including mid-SHIFT: the state goes to IDLE and the operation is aborted, with no done pulse. busy = 0, done = 0, out = 0, carry = 0, and the working registers and remaining are cleared.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- N = ceil(shamt / STEP). done is high in cycle N+1; for shamt = 0, that is cycle 1.
- busy is high in cycles 1..N and low in cycle N+1.
- Throughput: a new start in the done cycle begins the next operation, with that cycle as its cycle 0.
- out and carry are registered outputs with no combinational path from inputs.

## Test plan
- SLL, WIDTH = 16, STEP = 1: start with in = 0x0FFF, shamt = 1 → busy in cycle 1; done in cycle 2 with out = 0x1FFE, carry = 0.
- SRA, STEP = 1: in = 0x8001, shamt = 4 → done in cycle 5; out = 0xF800, carry = 0. Repeat with in = 0x800F → out = 0xF800, carry = 1.
- ROL, STEP = 4: in = 0x8001, shamt = 15 → done in cycle 5 (N = 4); out = 0xC000, carry = 0.
- Zero shift: SRL, in = 0x1234, shamt = 0 → done in cycle 1, busy never high, out = 0x1234, carry = 0.
- Handshake:
  - Issue SLL 0x0001 shamt = 3 (STEP = 1), and pulse start with different operands in cycle 2 → the cycle-2 start is ignored; done in cycle 4 with out = 0x0008.
  - A start in cycle 4 with SRL 0x0100 shamt = 8 → done in cycle 13, out = 0x0001.
- Reset mid-operation: assert reset in cycle 2 of SLL shamt = 10 → next cycle busy = 0, done = 0, out = 0, carry = 0; no done pulse follows. A start the cycle after reset deasserts completes normally.
